// File: rtl/demod_mix_integrate.sv
// demod_mix_integrate: I/Q carrier mixer followed by per-symbol integrate-and-dump.
// Optional macro DEMOD_MIX_ROUND_SAT_EN: round-half-up and saturate the dump instead of floor+wrap.
module demod_mix_integrate #(
  parameter int SIG_W     = 9,
  parameter int CAR_W     = 8,
  parameter int OUT_W     = 8,
  parameter int SYM_LEN   = 16,
  parameter int OUT_SHIFT = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    sym_start,
  input  logic signed [CAR_W-1:0] carrier_cos,
  input  logic signed [CAR_W-1:0] carrier_sin,
  input  logic signed [SIG_W-1:0] signal,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    aligned
);

  localparam int PROD_W = SIG_W + CAR_W;
  localparam int ACC_W  = PROD_W + $clog2(SYM_LEN);
  localparam int CNT_W  = $clog2(SYM_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYM_LEN - 1);

`ifdef DEMOD_MIX_ROUND_SAT_EN
  localparam logic signed [ACC_W:0] RND_ADD = (ACC_W+1)'(2 ** (OUT_SHIFT - 1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2 ** (OUT_W - 1)));
`endif

  typedef enum logic {ALIGN, RUN} state_t;

  logic signed [PROD_W-1:0] r_p_i, r_p_q;
  logic                     r_p_vld, r_p_start;
  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc_i, r_acc_q, w_acc_i_nxt, w_acc_q_nxt;
  logic signed [ACC_W-1:0]  w_p_i_ext, w_p_q_ext, w_sum_i, w_sum_q;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic signed [OUT_W-1:0]  r_out_i, r_out_q, w_out_i_nxt, w_out_q_nxt;
  logic                     r_out_vld, w_out_vld_nxt;

  // Accumulator-to-output scaling; the extra adder bit keeps the rounding offset overflow-free.
  function automatic logic signed [OUT_W-1:0] scale(input logic signed [ACC_W-1:0] x);
`ifdef DEMOD_MIX_ROUND_SAT_EN
    logic signed [ACC_W:0] rnd;
    rnd = ((ACC_W+1)'(x) + RND_ADD) >>> OUT_SHIFT;
    if (rnd > SAT_MAX)
      return OUT_W'(SAT_MAX);
    else if (rnd < SAT_MIN)
      return OUT_W'(SAT_MIN);
    else
      return OUT_W'(rnd);
`else
    return OUT_W'(x >>> OUT_SHIFT);
`endif
  endfunction

  // Product stage; products only load on valid samples so bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_i     <= '0;
      r_p_q     <= '0;
      r_p_vld   <= 1'b0;
      r_p_start <= 1'b0;
    end else begin
      r_p_vld   <= in_valid;
      r_p_start <= in_valid & sym_start;
      if (in_valid) begin
        r_p_i <= PROD_W'(carrier_cos) * PROD_W'(signal);
        r_p_q <= PROD_W'(carrier_sin) * PROD_W'(signal);
      end
    end
  end

  assign w_p_i_ext = ACC_W'(r_p_i);
  assign w_p_q_ext = ACC_W'(r_p_q);
  assign w_sum_i   = r_acc_i + w_p_i_ext;
  assign w_sum_q   = r_acc_q + w_p_q_ext;

  // A symbol start always restarts the integration, even on what would have been the dump sample.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_i_nxt   = r_acc_i;
    w_acc_q_nxt   = r_acc_q;
    w_cnt_nxt     = r_cnt;
    w_out_i_nxt   = r_out_i;
    w_out_q_nxt   = r_out_q;
    w_out_vld_nxt = 1'b0;
    case (r_state)
      ALIGN: begin
        if (r_p_vld && r_p_start) begin
          w_state_nxt = RUN;
          w_acc_i_nxt = w_p_i_ext;
          w_acc_q_nxt = w_p_q_ext;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      RUN: begin
        if (r_p_vld) begin
          if (r_p_start) begin
            w_acc_i_nxt = w_p_i_ext;
            w_acc_q_nxt = w_p_q_ext;
            w_cnt_nxt   = CNT_W'(1);
          end else if (r_cnt == LAST_CNT) begin
            w_out_i_nxt   = scale(w_sum_i);
            w_out_q_nxt   = scale(w_sum_q);
            w_out_vld_nxt = 1'b1;
            w_acc_i_nxt   = '0;
            w_acc_q_nxt   = '0;
            w_cnt_nxt     = '0;
          end else begin
            w_acc_i_nxt = w_sum_i;
            w_acc_q_nxt = w_sum_q;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ALIGN;
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_cnt     <= '0;
      r_out_i   <= '0;
      r_out_q   <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc_i   <= w_acc_i_nxt;
      r_acc_q   <= w_acc_q_nxt;
      r_cnt     <= w_cnt_nxt;
      r_out_i   <= w_out_i_nxt;
      r_out_q   <= w_out_q_nxt;
      r_out_vld <= w_out_vld_nxt;
    end
  end

  assign out_valid = r_out_vld;
  assign out_i     = r_out_i;
  assign out_q     = r_out_q;
  assign aligned   = (r_state == RUN);

endmodule

// File: tb/tb_demod_mix_integrate.sv
// Scoreboard bench for demod_mix_integrate: a default instance and an OUT_SHIFT=10 instance share stimulus.
// Expected dumps come from a queue-based symbol model; a negedge monitor pops and compares.
module tb_demod_mix_integrate;
  localparam int SYM_LEN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic sym_start = 1'b0;
  logic signed [7:0] carCos = '0;
  logic signed [7:0] carSin = '0;
  logic signed [8:0] sig = '0;

  logic ov13, al13, ov10, al10;
  logic signed [7:0] oi13, oq13, oi10, oq10;

  typedef struct {
    longint i;
    longint q;
    int     cyc;
  } exp_t;

  exp_t   sb13[$];
  exp_t   sb10[$];
  exp_t   e13, e10;
  longint symI[$];
  longint symQ[$];
  bit     mAligned = 1'b0;
  int     cyc = 0;
  int     nChecks = 0;
  int     nFails = 0;

  demod_mix_integrate dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sym_start(sym_start),
    .carrier_cos(carCos), .carrier_sin(carSin), .signal(sig),
    .out_valid(ov13), .out_i(oi13), .out_q(oq13), .aligned(al13)
  );

  demod_mix_integrate #(.OUT_SHIFT(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sym_start(sym_start),
    .carrier_cos(carCos), .carrier_sin(carSin), .signal(sig),
    .out_valid(ov10), .out_i(oi10), .out_q(oq10), .aligned(al10)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference scaling straight from the arithmetic definition.
  function automatic longint scaleRef(input longint acc, input int sh);
    longint r;
`ifdef DEMOD_MIX_ROUND_SAT_EN
    r = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`else
    r = (acc >>> sh) & 255;
    if (r >= 128) r = r - 256;
`endif
    return r;
  endfunction

  // Symbol model: collect products of the current symbol, dump when SYM_LEN have arrived.
  task automatic modelSample(input bit st, input longint pi, input longint pq, input int dueCyc);
    longint accI, accQ;
    exp_t   e;
    if (st) begin
      symI.delete();
      symQ.delete();
      mAligned = 1'b1;
    end
    if (!mAligned) return;
    symI.push_back(pi);
    symQ.push_back(pq);
    if (symI.size() == SYM_LEN) begin
      accI = 0;
      accQ = 0;
      foreach (symI[k]) begin
        accI += symI[k];
        accQ += symQ[k];
      end
      e.cyc = dueCyc;
      e.i = scaleRef(accI, 13);
      e.q = scaleRef(accQ, 13);
      sb13.push_back(e);
      e.i = scaleRef(accI, 10);
      e.q = scaleRef(accQ, 10);
      sb10.push_back(e);
      symI.delete();
      symQ.delete();
    end
  endtask

  // Drive one cycle of inputs at the falling edge; the following rising edge samples them.
  task automatic applyStimulus(input bit v, input bit st, input int c, input int s, input int g);
    @(negedge clk);
    in_valid  = v;
    sym_start = st;
    carCos    = 8'(c);
    carSin    = 8'(s);
    sig       = 9'(g);
    if (v) modelSample(st, longint'(c) * g, longint'(s) * g, cyc + 2);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    sym_start = 1'b0;
    symI.delete();
    symQ.delete();
    sb13.delete();
    sb10.delete();
    mAligned = 1'b0;
    #1;
    checkOutput("rst_out_valid", longint'(ov13), 0);
    checkOutput("rst_out_i", longint'(oi13), 0);
    checkOutput("rst_out_q", longint'(oq13), 0);
    checkOutput("rst_aligned", longint'(al13), 0);
    checkOutput("rst10_out_valid", longint'(ov10), 0);
    checkOutput("rst10_aligned", longint'(al10), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int rc, rs, rg;

  // Monitor: every pulse must match the oldest pending expectation, in value and in cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov13) begin
        if (sb13.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_dump13: got out_valid=1, expected no pending symbol (cycle %0d)", cyc);
        end else begin
          e13 = sb13.pop_front();
          checkOutput("out_i", longint'(oi13), e13.i);
          checkOutput("out_q", longint'(oq13), e13.q);
          checkOutput("latency", longint'(cyc), longint'(e13.cyc));
        end
      end
      if (ov10) begin
        if (sb10.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_dump10: got out_valid=1, expected no pending symbol (cycle %0d)", cyc);
        end else begin
          e10 = sb10.pop_front();
          checkOutput("out_i_sh10", longint'(oi10), e10.i);
          checkOutput("out_q_sh10", longint'(oq10), e10.q);
          checkOutput("latency_sh10", longint'(cyc), longint'(e10.cyc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();

    // Partial symbol then reset; unaligned samples afterwards must not produce a dump.
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, k == 0, 100, -50, 200);
    doReset();
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, 127, -128, 255);
    idle(4);
    checkOutput("aligned_no_start", longint'(al13), 0);

    // Constant symbol: 63 / -64 for the default scaling.
    for (int k = 0; k < SYM_LEN; k++) applyStimulus(1'b1, k == 0, 127, -128, 255);
    idle(4);
    checkOutput("aligned_after_start", longint'(al13), 1);
    checkOutput("held_out_i", longint'(oi13), 63);
    checkOutput("held_out_q", longint'(oq13), -64);

    // Same symbol with a bubble after every sample.
    for (int k = 0; k < SYM_LEN; k++) begin
      applyStimulus(1'b1, k == 0, 127, -128, 255);
      applyStimulus(1'b0, 1'b0, 5, 5, 5);
    end
    idle(4);

    // Re-align at sample 10, including a restart on the would-be last sample.
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, k == 0, 60, -70, 100 + k);
    for (int k = 0; k < SYM_LEN; k++) applyStimulus(1'b1, k == 0, -90, 33, 150 - k);
    for (int k = 0; k < SYM_LEN - 1; k++) applyStimulus(1'b1, k == 0, 11, 22, 33);
    for (int k = 0; k < SYM_LEN; k++) applyStimulus(1'b1, k == 0, 45, -45, -200);
    idle(4);

    // Large positive accumulation: wraps or saturates in the OUT_SHIFT=10 instance.
    for (int k = 0; k < SYM_LEN; k++) applyStimulus(1'b1, k == 0, -128, 0, -256);
    idle(4);

    // Free-running symbols after a single start.
    for (int k = 0; k < 3 * SYM_LEN; k++) begin
      rc = int'($urandom_range(255)) - 128;
      rs = int'($urandom_range(255)) - 128;
      rg = int'($urandom_range(511)) - 256;
      applyStimulus(1'b1, k == 0, rc, rs, rg);
    end
    idle(4);

    // Random traffic with bubbles and occasional restarts.
    for (int k = 0; k < 400; k++) begin
      rc = int'($urandom_range(255)) - 128;
      rs = int'($urandom_range(255)) - 128;
      rg = int'($urandom_range(511)) - 256;
      applyStimulus($urandom_range(3) != 0, $urandom_range(23) == 0, rc, rs, rg);
    end
    idle(6);

    checkOutput("pending13", longint'(sb13.size()), 0);
    checkOutput("pending10", longint'(sb10.size()), 0);
    checkOutput("aligned_end13", longint'(al13), longint'(mAligned));
    checkOutput("aligned_end10", longint'(al10), longint'(mAligned));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
